riscv_pipe_ctrl: RTL and testbench
==================================

RISCV_PIPE_CTRL -- requirements
Module: riscv_pipe_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W     32  write-back data width
  REG_AW     5   register address width (4 for RV32E)
  CNT_W      32  retired-instruction counter width
  DRAIN_CYC  3   cycles to drain older instructions after a halt is accepted
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk                  in   1       sole clock, rising edge
  reset                in   1       synchronous, active-high
  id_rs1, id_rs2       in   REG_AW  source registers of the instruction in ID
  id_use1, id_use2     in   1       the ID instruction reads rs1 / rs2
  id_halt              in   1       the ID instruction is HALT
  ex_rs1, ex_rs2       in   REG_AW  source registers of the instruction in EX
  ex_rd                in   REG_AW  destination register in EX
  ex_memread           in   1       the EX instruction is a load
  ex_redirect          in   1       taken branch, JAL or JALR resolved in EX
  mem_rd, mem_regwrite in   REG_AW,1  destination register and write flag in MEM
  wb_rd, wb_regwrite   in   REG_AW,1  destination register and write flag in WB
  wb_valid             in   1       a real instruction retires in WB
  wb_data              in   DATA_W  write-back value
  pc_en, ifid_en       out  1       PC and IF/ID register enables
  ifid_flush, idex_flush out 1      bubble insert into IF/ID and ID/EX
  fwd_a, fwd_b         out  2       EX operand select: 00 register file, 01 WB, 10 MEM
  halted               out  1       core is stopped
  reg_num              out  REG_AW  trace: register written
  reg_data             out  DATA_W  trace: value written
  reg_write_sig        out  1       trace: write strobe
  retired_cnt          out  CNT_W   retired-instruction count

Function
REQ-003 fwd_a SHALL be 10 when mem_regwrite, mem_rd!=0 and mem_rd==ex_rs1; else 01 when wb_regwrite, wb_rd!=0 and wb_rd==ex_rs1; else 00. fwd_b SHALL follow the same rule using ex_rs2. The output SHALL be combinational.
REQ-004 A load-use hazard SHALL exist when ex_memread is set, ex_rd!=0, and (id_use1 and id_rs1==ex_rd) or (id_use2 and id_rs2==ex_rd). On a hazard: pc_en=0, ifid_en=0, idex_flush=1, ifid_flush=0.
REQ-005 An ex_redirect SHALL produce ifid_flush=1, idex_flush=1, pc_en=1 and ifid_en=1 in the same cycle. Redirect SHALL take priority over the load-use stall and over id_halt.
REQ-006 The FSM SHALL have the states RUN, DRAIN and HALTED.
REQ-007 In RUN, id_halt with no redirect and no hazard SHALL load the drain counter with DRAIN_CYC-1, assert pc_en=0, ifid_en=0 and idex_flush=1, and go to DRAIN on the next edge.
REQ-008 In DRAIN, pc_en=0 and ifid_en=0 SHALL hold, and the counter SHALL decrement each cycle. At count 0 the FSM SHALL go to HALTED.
REQ-009 An ex_redirect during DRAIN (wrong-path halt) SHALL apply REQ-005 and return the FSM to RUN on the next edge.
REQ-010 In HALTED, halted=1, pc_en=0, ifid_en=0 and idex_flush=1. HALTED SHALL be left only by reset. Forwarding and trace SHALL continue to operate.
REQ-011 With no other condition active, outputs SHALL be pc_en=1, ifid_en=1 and both flushes 0.
REQ-012 Trace outputs SHALL be registered, with 1-cycle latency. On each edge, reg_write_sig <= wb_valid & wb_regwrite & (wb_rd!=0). reg_num and reg_data SHALL capture wb_rd and wb_data only when that strobe is 1, and hold otherwise.
REQ-013 retired_cnt SHALL increment by 1 on each edge where wb_valid=1, and SHALL saturate at all-ones with no wrap.

Reset
REQ-014 On a clock edge with reset=1: state=RUN, drain counter=0, retired_cnt=0, reg_num=0, reg_data=0, reg_write_sig=0, halted=0.
REQ-015 While reset=1, combinational outputs SHALL be pc_en=0, ifid_en=0, ifid_flush=1, idex_flush=1 and fwd_a=fwd_b=00. Reset in DRAIN or HALTED SHALL return the block to RUN.

Structure
REQ-016 Package riscv_pipe_pkg SHALL hold the state enum (RUN, DRAIN, HALTED) and the forwarding-select constants FWD_RF, FWD_WB and FWD_MEM.
REQ-017 Forwarding compare SHALL be sub-module riscv_fwd_unit, instantiated once per operand. All other logic SHALL be flat in riscv_pipe_ctrl.

Verification
REQ-018 mem_regwrite=1, mem_rd=5, wb_regwrite=1, wb_rd=5, ex_rs1=5, ex_rs2=5 -> fwd_a=fwd_b=10. Set mem_rd=0 -> both 01.
REQ-019 ex_memread=1, ex_rd=7, id_use2=1, id_rs2=7 -> pc_en=0, ifid_en=0, idex_flush=1. Same cycle with ex_redirect=1 -> pc_en=1, ifid_flush=1.
REQ-020 id_halt=1 in RUN with DRAIN_CYC=3 -> pc_en=0 immediately, halted=1 exactly 4 edges later. Stays halted until reset.
REQ-021 id_halt accepted, then ex_redirect=1 in the first DRAIN cycle -> next cycle state RUN, pc_en=1, halted never 1.
REQ-022 wb_valid=1, wb_regwrite=1, wb_rd=3, wb_data=0xDEADBEEF -> next cycle reg_write_sig=1, reg_num=3, reg_data=0xDEADBEEF. With wb_rd=0 -> strobe 0 and values held. CNT_W=4 with 20 retirements -> retired_cnt=15.
REQ-023 Assert reset for 1 cycle while HALTED -> state RUN, retired_cnt=0, all trace outputs 0.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the pipeline hazard/control block.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/riscv_fwd_unit.sv
// EX operand bypass select for one source register; MEM result wins over WB.
import riscv_pipe_pkg::*;

module riscv_fwd_unit #(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        fwd_sel_c
);

  always_comb begin
    fwd_sel_c = FWD_RF;
    if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      fwd_sel_c = FWD_MEM;
    end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      fwd_sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/riscv_pipe_ctrl.sv
// Pipeline control: forwarding, load-use stall, redirect flush, halt drain,
// write-back trace and retired-instruction counter.
import riscv_pipe_pkg::*;

module riscv_pipe_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned DRAIN_CYC = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic              id_halt,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_redirect,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_data,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              halted,
  output logic [REG_AW-1:0] reg_num,
  output logic [DATA_W-1:0] reg_data,
  output logic              reg_write_sig,
  output logic [CNT_W-1:0]  retired_cnt
);

  localparam int unsigned DC_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  pipe_state_e     state, state_nx;
  logic [DC_W-1:0] drain_cnt, drain_cnt_nx;
  logic            hazard_c;
  logic            trace_wr_c;
  logic [1:0]      fwd_a_c, fwd_b_c;

  riscv_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_rs        (ex_rs1),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .fwd_sel_c    (fwd_a_c)
  );

  riscv_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_rs        (ex_rs2),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .fwd_sel_c    (fwd_b_c)
  );

  assign fwd_a = reset ? FWD_RF : fwd_a_c;
  assign fwd_b = reset ? FWD_RF : fwd_b_c;

  assign hazard_c = ex_memread && (ex_rd != '0) &&
                    ((id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd)));

  assign trace_wr_c = wb_valid && wb_regwrite && (wb_rd != '0);

  // Next state and pipeline enables; redirect beats stall and halt.
  always_comb begin
    state_nx     = state;
    drain_cnt_nx = drain_cnt;
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    if (reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (ex_redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (hazard_c) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end else if (id_halt) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_flush   = 1'b1;
            drain_cnt_nx = DC_W'(DRAIN_CYC - 1);
            state_nx     = DRAIN;
          end
        end
        DRAIN: begin
          if (ex_redirect) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            drain_cnt_nx = '0;
            state_nx     = RUN;
          end else begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            if (drain_cnt == '0) begin
              state_nx = HALTED;
            end else begin
              drain_cnt_nx = drain_cnt - DC_W'(1);
            end
          end
        end
        HALTED: begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
        default: begin
          state_nx     = RUN;
          drain_cnt_nx = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      drain_cnt     <= '0;
      halted        <= 1'b0;
      reg_write_sig <= 1'b0;
      reg_num       <= '0;
      reg_data      <= '0;
      retired_cnt   <= '0;
    end else begin
      state         <= state_nx;
      drain_cnt     <= drain_cnt_nx;
      halted        <= (state_nx == HALTED);
      reg_write_sig <= trace_wr_c;
      if (trace_wr_c) begin
        reg_num  <= wb_rd;
        reg_data <= wb_data;
      end
      // Saturating count keeps a long run from wrapping to a small value.
      if (wb_valid && (retired_cnt != '1)) begin
        retired_cnt <= retired_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Directed plus randomized bench for riscv_pipe_ctrl against a cycle-level model.
module tb_riscv_pipe_ctrl;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned DRAIN_CYC = 3;
  localparam int          CNT_MAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use1, id_use2, id_halt, ex_memread, ex_redirect;
  logic mem_regwrite, wb_regwrite, wb_valid;
  logic [DATA_W-1:0] wb_data;
  logic pc_en, ifid_en, ifid_flush, idex_flush, halted, reg_write_sig;
  logic [1:0] fwd_a, fwd_b;
  logic [REG_AW-1:0] reg_num;
  logic [DATA_W-1:0] reg_data;
  logic [CNT_W-1:0] retired_cnt;

  int checks = 0;
  int errors = 0;

  // Model: edges since halt accepted (0 = not draining), sticky halt, trace values.
  int          m_since  = 0;
  bit          m_halted = 1'b0;
  bit          e_sig    = 1'b0;
  int          e_num    = 0;
  logic [31:0] e_data   = '0;
  int          e_cnt    = 0;

  riscv_pipe_ctrl #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
    .id_halt(id_halt),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_valid(wb_valid), .wb_data(wb_data),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
    .reg_num(reg_num), .reg_data(reg_data), .reg_write_sig(reg_write_sig),
    .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_fwd(input logic [REG_AW-1:0] rs);
    if (reset) return 0;
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 1;
    return 0;
  endfunction

  function automatic bit load_use();
    return ex_memread && ex_rd != 0 &&
           ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
  endfunction

  task automatic clear_inputs();
    reset = 1'b0;
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_use1, id_use2, id_halt, ex_memread, ex_redirect} = '0;
    {mem_regwrite, wb_regwrite, wb_valid} = '0;
    wb_data = '0;
  endtask

  // Check every output against the model, take one edge, advance the model.
  task automatic step();
    bit e_pc, e_ifid, e_iff, e_idf, sig;
    #1;
    e_pc = 1; e_ifid = 1; e_iff = 0; e_idf = 0;
    if (reset) begin
      e_pc = 0; e_ifid = 0; e_iff = 1; e_idf = 1;
    end else if (m_halted) begin
      e_pc = 0; e_ifid = 0; e_idf = 1;
    end else if (ex_redirect) begin
      e_iff = 1; e_idf = 1;
    end else if (m_since > 0 || load_use() || id_halt) begin
      e_pc = 0; e_ifid = 0; e_idf = 1;
    end
    chk("pc_en", 64'(pc_en), 64'(e_pc));
    chk("ifid_en", 64'(ifid_en), 64'(e_ifid));
    chk("ifid_flush", 64'(ifid_flush), 64'(e_iff));
    chk("idex_flush", 64'(idex_flush), 64'(e_idf));
    chk("fwd_a", 64'(fwd_a), 64'(exp_fwd(ex_rs1)));
    chk("fwd_b", 64'(fwd_b), 64'(exp_fwd(ex_rs2)));
    chk("halted", 64'(halted), 64'(m_halted));
    chk("reg_write_sig", 64'(reg_write_sig), 64'(e_sig));
    chk("reg_num", 64'(reg_num), 64'(e_num));
    chk("reg_data", 64'(reg_data), 64'(e_data));
    chk("retired_cnt", 64'(retired_cnt), 64'(e_cnt));
    @(posedge clk);
    if (reset) begin
      m_since = 0; m_halted = 0;
      e_sig = 0; e_num = 0; e_data = '0; e_cnt = 0;
    end else begin
      sig = wb_valid && wb_regwrite && wb_rd != 0;
      e_sig = sig;
      if (sig) begin
        e_num = int'(wb_rd);
        e_data = wb_data;
      end
      if (wb_valid && e_cnt < CNT_MAX) e_cnt++;
      if (!m_halted) begin
        if (m_since > 0) begin
          if (ex_redirect) m_since = 0;
          else begin
            m_since++;
            if (m_since == DRAIN_CYC + 1) begin
              m_halted = 1;
              m_since = 0;
            end
          end
        end else if (!ex_redirect && !load_use() && id_halt) begin
          m_since = 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Reset state and reset-time combinational outputs.
    reset = 1'b1;
    ex_rs1 = 5; mem_rd = 5; mem_regwrite = 1;
    step();
    clear_inputs();
    step();

    // Forwarding priority: MEM over WB, then WB when MEM targets x0.
    mem_regwrite = 1; mem_rd = 5; wb_regwrite = 1; wb_rd = 5; ex_rs1 = 5; ex_rs2 = 5;
    #1 chk("fwd_a_mem", 64'(fwd_a), 64'd2);
    chk("fwd_b_mem", 64'(fwd_b), 64'd2);
    step();
    mem_rd = 0;
    #1 chk("fwd_a_wb", 64'(fwd_a), 64'd1);
    chk("fwd_b_wb", 64'(fwd_b), 64'd1);
    step();
    clear_inputs();

    // Load-use stall, then the same hazard overridden by a redirect.
    ex_memread = 1; ex_rd = 7; id_use2 = 1; id_rs2 = 7;
    step();
    ex_redirect = 1;
    #1 chk("redirect_pc_en", 64'(pc_en), 64'd1);
    chk("redirect_ifid_flush", 64'(ifid_flush), 64'd1);
    step();
    clear_inputs();

    // Trace capture, then x0 write leaves the captured values alone.
    wb_valid = 1; wb_regwrite = 1; wb_rd = 3; wb_data = 32'hDEADBEEF;
    step();
    #1 chk("trace_data", 64'(reg_data), 64'hDEADBEEF);
    wb_rd = 0; wb_data = 32'h12345678;
    step();
    wb_valid = 0;
    #1 chk("trace_hold_num", 64'(reg_num), 64'd3);
    chk("trace_hold_strobe", 64'(reg_write_sig), 64'd0);
    step();

    // Retired counter saturates.
    do_reset();
    wb_valid = 1;
    for (int i = 0; i < 20; i++) step();
    wb_valid = 0;
    #1 chk("retired_sat", 64'(retired_cnt), 64'(CNT_MAX));
    step();

    // Halt drains for DRAIN_CYC cycles then stops until reset.
    do_reset();
    id_halt = 1;
    #1 chk("halt_pc_en", 64'(pc_en), 64'd0);
    step();
    id_halt = 0;
    for (int i = 0; i < 2; i++) step();
    #1 chk("not_yet_halted", 64'(halted), 64'd0);
    step();
    #1 chk("halted_after_4", 64'(halted), 64'd1);
    ex_redirect = 1;
    for (int i = 0; i < 5; i++) step();
    ex_redirect = 0;
    #1 chk("still_halted", 64'(halted), 64'd1);
    wb_valid = 1; wb_regwrite = 1; wb_rd = 9; wb_data = 32'hCAFE0001;
    step();
    do_reset();
    #1 chk("reset_from_halt", 64'(halted), 64'd0);
    chk("reset_cnt", 64'(retired_cnt), 64'd0);
    chk("reset_num", 64'(reg_num), 64'd0);
    step();

    // Redirect in the first drain cycle cancels the halt.
    id_halt = 1;
    step();
    id_halt = 0; ex_redirect = 1;
    step();
    ex_redirect = 0;
    #1 chk("cancel_pc_en", 64'(pc_en), 64'd1);
    for (int i = 0; i < 6; i++) step();
    #1 chk("cancel_never_halted", 64'(halted), 64'd0);

    // Randomized traffic with small register indices for frequent matches.
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 59) == 0);
      id_rs1       = REG_AW'($urandom_range(0, 7));
      id_rs2       = REG_AW'($urandom_range(0, 7));
      id_use1      = 1'($urandom);
      id_use2      = 1'($urandom);
      id_halt      = ($urandom_range(0, 11) == 0);
      ex_rs1       = REG_AW'($urandom_range(0, 7));
      ex_rs2       = REG_AW'($urandom_range(0, 7));
      ex_rd        = REG_AW'($urandom_range(0, 7));
      ex_memread   = ($urandom_range(0, 2) == 0);
      ex_redirect  = ($urandom_range(0, 5) == 0);
      mem_rd       = REG_AW'($urandom_range(0, 7));
      mem_regwrite = 1'($urandom);
      wb_rd        = REG_AW'($urandom_range(0, 7));
      wb_regwrite  = 1'($urandom);
      wb_valid     = 1'($urandom);
      wb_data      = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
